// File: rtl/rsa_key_setup.sv
// rsa_key_setup: turns a prime pair (P, Q) and public exponent E into the
// RSA modulus N = P*Q and totient PHI = (P-1)*(Q-1), and validates the key.
// Both products share one LSB-first shift-add multiplier (one bit per cycle).
// Optional feature macro: RSA_KEY_SETUP_GCD_EN adds the binary-GCD coprimality
// check (err=3); without it the latency is fixed at 2*H+2 cycles.
module rsa_key_setup #(
  parameter int unsigned WORD_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [WORD_WIDTH/2-1:0]   P,
  input  logic [WORD_WIDTH/2-1:0]   Q,
  input  logic [WORD_WIDTH-1:0]     E,
  output logic                      busy,
  output logic                      done,
  output logic [WORD_WIDTH-1:0]     N,
  output logic [WORD_WIDTH-1:0]     PHI,
  output logic                      key_valid,
  output logic [1:0]                err
);

  localparam int unsigned W  = WORD_WIDTH;
  localparam int unsigned H  = WORD_WIDTH / 2;
  localparam int unsigned CW = $clog2(H + 1);
`ifdef RSA_KEY_SETUP_GCD_EN
  localparam int unsigned GW = $clog2(2 * W + 1);
`endif

  typedef enum logic [2:0] {
    IDLE, LOAD, MUL_N, MUL_PHI, GCD, FINISH
  } state_t;

  state_t          state;
  logic [H-1:0]    p_r;
  logic [H-1:0]    q_r;
  logic [W-1:0]    e_r;
  logic [W-1:0]    acc;
  logic [W-1:0]    mcand;
  logic [H-1:0]    mplier;
  logic [CW-1:0]   cnt;
  logic [W-1:0]    n_tmp;
`ifdef RSA_KEY_SETUP_GCD_EN
  logic [W-1:0]    phi_tmp;
  logic [W-1:0]    gcd_a;
  logic [W-1:0]    gcd_b;
  logic [GW-1:0]   gcnt;
`endif

  logic [W-1:0]    acc_next;
  logic            mul_last;
  logic            e_bad;

  // Shift-add step: accumulator value after consuming the current multiplier bit.
  always_comb begin
    acc_next = acc + (mplier[0] ? mcand : '0);
    mul_last = (cnt == CW'(H - 1));
    e_bad    = (e_r <= W'(1)) || (e_r >= acc_next);
  end

  // Key-setup sequencer: operand capture, two multiplies, checks, GCD, result update.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      N         <= '0;
      PHI       <= '0;
      key_valid <= 1'b0;
      err       <= 2'd0;
      p_r       <= '0;
      q_r       <= '0;
      e_r       <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      cnt       <= '0;
      n_tmp     <= '0;
`ifdef RSA_KEY_SETUP_GCD_EN
      phi_tmp   <= '0;
      gcd_a     <= '0;
      gcd_b     <= '0;
      gcnt      <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            p_r   <= P;
            q_r   <= Q;
            e_r   <= E;
            busy  <= 1'b1;
            state <= LOAD;
          end
        end

        LOAD: begin
          acc    <= '0;
          mcand  <= W'(p_r);
          mplier <= q_r;
          cnt    <= '0;
          state  <= MUL_N;
        end

        MUL_N: begin
          if (mul_last) begin
            n_tmp  <= acc_next;
            acc    <= '0;
            mcand  <= W'(p_r - H'(1));
            mplier <= q_r - H'(1);
            cnt    <= '0;
            state  <= MUL_PHI;
          end else begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
          end
        end

        MUL_PHI: begin
          if (mul_last) begin
`ifdef RSA_KEY_SETUP_GCD_EN
            phi_tmp <= acc_next;
`endif
            if (p_r == q_r) begin
              N         <= n_tmp;
              PHI       <= acc_next;
              err       <= 2'd1;
              key_valid <= 1'b0;
              done      <= 1'b1;
              state     <= FINISH;
            end else if (e_bad) begin
              N         <= n_tmp;
              PHI       <= acc_next;
              err       <= 2'd2;
              key_valid <= 1'b0;
              done      <= 1'b1;
              state     <= FINISH;
            end else begin
`ifdef RSA_KEY_SETUP_GCD_EN
              gcd_a <= e_r;
              gcd_b <= acc_next;
              gcnt  <= '0;
              state <= GCD;
`else
              N         <= n_tmp;
              PHI       <= acc_next;
              err       <= 2'd0;
              key_valid <= 1'b1;
              done      <= 1'b1;
              state     <= FINISH;
`endif
            end
          end else begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
          end
        end

`ifdef RSA_KEY_SETUP_GCD_EN
        GCD: begin
          gcnt <= gcnt + GW'(1);
          if (gcd_a == '0 || gcd_b == '0) begin
            // One operand reached zero: the other one is the gcd.
            N         <= n_tmp;
            PHI       <= phi_tmp;
            err       <= ((gcd_a | gcd_b) == W'(1)) ? 2'd0 : 2'd3;
            key_valid <= ((gcd_a | gcd_b) == W'(1));
            done      <= 1'b1;
            state     <= FINISH;
          end else if ((!gcd_a[0] && !gcd_b[0]) || gcnt == GW'(2 * W - 1)) begin
            // Common factor of two, or iteration budget exhausted.
            N         <= n_tmp;
            PHI       <= phi_tmp;
            err       <= 2'd3;
            key_valid <= 1'b0;
            done      <= 1'b1;
            state     <= FINISH;
          end else if (!gcd_a[0]) begin
            gcd_a <= gcd_a >> 1;
          end else if (!gcd_b[0]) begin
            gcd_b <= gcd_b >> 1;
          end else if (gcd_a > gcd_b) begin
            gcd_a <= gcd_a - gcd_b;
          end else begin
            gcd_b <= gcd_b - gcd_a;
          end
        end
`endif

        FINISH: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
